// File: rtl/bs_pkg.sv
// Shared types for the binary-search engine: FSM states and search modes.
package bs_pkg;

    typedef enum logic [1:0] {IDLE, READ, CMP, DONE} bs_state_t;
    typedef enum logic {BS_EXACT, BS_LOWER} bs_mode_t;

endpackage

// File: rtl/bs_engine.sv
// Parametrised binary search over an external ascending-sorted 1-cycle-latency RAM.
// Optional probe counter built only when BS_PROBE_CNT_EN is defined.
module bs_engine
    import bs_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 32,
    parameter int PROBE_W = 4
) (
    input  logic                clk,
    input  logic                Reset_n,
    input  logic                Start,
    input  logic                Mode,
    input  logic [DATA_W-1:0]   A,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                Done,
    output logic                Found,
    output logic [ADDR_W:0]     Loc,
    output logic [PROBE_W-1:0]  Probes
);

    localparam int LW = ADDR_W + 1;
    localparam logic [LW-1:0] HI_INIT = LW'(DEPTH - 1);
    localparam logic [LW-1:0] ONE     = LW'(1);

    bs_state_t           state, state_n;
    bs_mode_t            mode_q, mode_n;
    logic [DATA_W-1:0]   target_q, target_n;
    logic [LW-1:0]       lo, lo_n, hi, hi_n, mid;
    logic [LW-1:0]       loc_q, loc_n;
    logic                found_q, found_n;
    logic [ADDR_W-1:0]   addr_q;
    logic                go_low, empty;

    // Halving each bound separately keeps mid within LW bits without a carry bit.
    assign mid = (lo >> 1) + (hi >> 1) + {{(LW-1){1'b0}}, lo[0] & hi[0]};

    always_comb begin
        state_n  = state;
        mode_n   = mode_q;
        target_n = target_q;
        lo_n     = lo;
        hi_n     = hi;
        loc_n    = loc_q;
        found_n  = found_q;
        go_low   = 1'b0;
        empty    = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    mode_n   = bs_mode_t'(Mode);
                    target_n = A;
                    lo_n     = '0;
                    hi_n     = HI_INIT;
                    loc_n    = '0;
                    found_n  = 1'b0;
                    state_n  = READ;
                end
            end
            READ: state_n = CMP;
            CMP: begin
                if (mode_q == BS_EXACT && mem_rdata == target_q) begin
                    found_n = 1'b1;
                    loc_n   = mid;
                    state_n = DONE;
                end else begin
                    go_low = (mode_q == BS_EXACT) ? (mem_rdata > target_q)
                                                  : (mem_rdata >= target_q);
                    if (go_low) begin
                        if (mode_q == BS_LOWER) begin
                            loc_n   = mid;
                            found_n = (mem_rdata == target_q);
                        end
                        if (mid == '0) empty = 1'b1;
                        else           hi_n  = mid - ONE;
                    end else begin
                        lo_n = mid + ONE;
                    end
                    if (empty || lo_n > hi_n) begin
                        state_n = DONE;
                        // Final lo is the lower bound, including DEPTH when all data < A.
                        if (mode_q == BS_LOWER) loc_n = lo_n;
                    end else begin
                        state_n = READ;
                    end
                end
            end
            DONE: if (!Start) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            mode_q   <= BS_EXACT;
            target_q <= '0;
            lo       <= '0;
            hi       <= '0;
            loc_q    <= '0;
            found_q  <= 1'b0;
            addr_q   <= '0;
        end else begin
            state    <= state_n;
            mode_q   <= mode_n;
            target_q <= target_n;
            lo       <= lo_n;
            hi       <= hi_n;
            loc_q    <= loc_n;
            found_q  <= found_n;
            if (state == READ) addr_q <= mid[ADDR_W-1:0];
        end
    end

    assign mem_addr = (state == READ) ? mid[ADDR_W-1:0] : addr_q;
    assign Done     = (state == DONE);
    assign Found    = found_q;
    assign Loc      = loc_q;

`ifdef BS_PROBE_CNT_EN
    logic [PROBE_W-1:0] probes_q;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            probes_q <= '0;
        end else if (state == IDLE && Start) begin
            probes_q <= '0;
        end else if (state == CMP && probes_q != '1) begin
            probes_q <= probes_q + PROBE_W'(1);
        end
    end

    assign Probes = probes_q;
`else
    assign Probes = '0;
`endif

endmodule

// File: tb/tb_bs_engine.sv
// Self-checking bench for bs_engine: directed cases on data[i]=2i+1 plus randomized sorted RAMs.
module tb_bs_engine;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int DP = 32;
    localparam int PW = 4;

    logic          clk;
    logic          Reset_n;
    logic          Start;
    logic          Mode;
    logic [DW-1:0] A;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          Done;
    logic          Found;
    logic [AW:0]   Loc;
    logic [PW-1:0] Probes;

    logic [DW-1:0] ram [DP];

    int n_cmp = 0;
    int n_bad = 0;

    bit exp_valid = 0;
    int m_a, m_mode, m_found, m_loc, m_probes;

    bs_engine #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .PROBE_W(PW)) dut (
        .clk       (clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Mode      (Mode),
        .A         (A),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .Done      (Done),
        .Found     (Found),
        .Loc       (Loc),
        .Probes    (Probes)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= ram[mem_addr];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Probe count of an ideal binary search over the current RAM contents.
    function automatic int model_probes(input int a, input int mode);
        int lo = 0;
        int hi = DP - 1;
        int k = 0;
        while (lo <= hi) begin
            int mid = (lo + hi) / 2;
            k++;
            if (mode == 0 && int'(ram[mid]) == a) return k;
            if (int'(ram[mid]) < a) lo = mid + 1;
            else                    hi = mid - 1;
        end
        return k;
    endfunction

    always @(negedge clk) begin
        if (exp_valid && Reset_n) begin
            chk("found", int'(Found), m_found);
            if (m_mode == 0 && m_found == 1)
                chk("loc_data", (Loc < DP) ? int'(ram[Loc[AW-1:0]]) : -1, m_a);
            else
                chk("loc", int'(Loc), m_loc);
            chk("probes", int'(Probes), m_probes);
        end
    end

    task automatic run(input int a, input int mode, input bit hold,
                       input int lit_found, input int lit_loc, input int lit_k);
        int cyc;
        int k;
        @(posedge clk); #1;
        exp_valid = 0;
        A = DW'(a);
        Mode = mode[0];
        Start = 1;
        @(posedge clk); #1;
        if (!hold) Start = 0;
        A = DW'($urandom);
        Mode = 1'($urandom);
        cyc = 0;
        while (!Done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        m_a = a;
        m_mode = mode;
        m_found = 0;
        m_loc = (mode == 0) ? 0 : DP;
        for (int i = DP - 1; i >= 0; i--) begin
            if (mode == 0 && int'(ram[i]) == a) m_found = 1;
            if (mode == 1 && int'(ram[i]) >= a) m_loc = i;
        end
        if (mode == 1) m_found = (m_loc < DP && int'(ram[m_loc]) == a) ? 1 : 0;
        k = model_probes(a, mode);
`ifdef BS_PROBE_CNT_EN
        m_probes = (k > 15) ? 15 : k;
`else
        m_probes = 0;
`endif
        chk("latency", cyc, 2 * k);
        exp_valid = 1;
        if (lit_found >= 0) begin
            chk("lit_found", int'(Found), lit_found);
            chk("lit_loc", int'(Loc), lit_loc);
            chk("lit_max_probes", (cyc <= 12) ? 1 : 0, 1);
        end
        if (lit_k >= 0) chk("lit_cycles", cyc, 2 * lit_k);
        if (hold) begin
            repeat (3) begin
                @(posedge clk); #1;
                chk("done_hold", int'(Done), 1);
            end
            Start = 0;
        end
        @(posedge clk); #1;
        chk("done_fall", int'(Done), 0);
    endtask

    task automatic fill_odd();
        for (int i = 0; i < DP; i++) ram[i] = DW'(2 * i + 1);
    endtask

    task automatic fill_random();
        int v = $urandom_range(0, 6);
        for (int i = 0; i < DP; i++) begin
            ram[i] = DW'(v);
            v += $urandom_range(0, 7);
            if (v > 255) v = 255;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 0;
        Start = 0;
        Mode = 0;
        A = '0;
        fill_odd();
        #3;
        chk("rst_done", int'(Done), 0);
        chk("rst_found", int'(Found), 0);
        chk("rst_loc", int'(Loc), 0);
        chk("rst_probes", int'(Probes), 0);
        chk("rst_addr", int'(mem_addr), 0);
        @(posedge clk); #1;
        Reset_n = 1;

        run(31, 0, 0, 1, 15, 1);
        run(1,  0, 1, 1, 0, -1);
        run(63, 0, 0, 1, 31, -1);
        run(0,  0, 0, 0, 0, -1);
        run(64, 0, 1, 0, 0, -1);
        run(20, 1, 0, 0, 10, -1);
        run(21, 1, 0, 1, 10, -1);
        run(0,  1, 1, 0, 0, -1);
        run(64, 1, 0, 0, 32, -1);

        // Abort in CMP: outputs must clear at once, including the held address.
        run(21, 1, 0, 1, 10, -1);
        @(posedge clk); #1;
        exp_valid = 0;
        A = DW'(0);
        Mode = 0;
        Start = 1;
        @(posedge clk); #1;
        Start = 0;
        @(posedge clk); #1;
        Reset_n = 0;
        #1;
        chk("abort_done", int'(Done), 0);
        chk("abort_found", int'(Found), 0);
        chk("abort_loc", int'(Loc), 0);
        chk("abort_probes", int'(Probes), 0);
        chk("abort_addr", int'(mem_addr), 0);
        @(posedge clk); #1;
        Reset_n = 1;
        run(63, 0, 0, 1, 31, -1);

        for (int t = 0; t < 40; t++) begin
            int a;
            @(posedge clk); #1;
            exp_valid = 0;
            fill_random();
            a = ($urandom_range(0, 1) == 1) ? int'(ram[$urandom_range(0, DP - 1)])
                                           : int'($urandom_range(0, 255));
            run(a, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 0, -1);
        end

        @(posedge clk); #1;
        exp_valid = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
